arranged_frame_serializer: RTL and testbench

- Consumes one 10-nibble frame produced by the `arrange` odd/even sorting block and streams it out one nibble per handshake.
- Position 0 (`A_out`) goes first and position 9 (`J_out`) goes last. Each nibble carries its position, parity and a last-of-frame tag.
- Reports how many odd nibbles the frame holds.
- Sits on the output side of `arrange`, turning its wide parallel result into a narrow valid/ready stream for downstream logic.

---
 rtl/arranged_frame_serializer.sv | 126 ++++++++++++
 tb/tb_arranged_frame_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/arranged_frame_serializer.sv
// Streams one N-nibble frame from the arrange block as a valid/ready nibble stream, position 0 first.
// Define ARRANGE_PARTITION_CHECK_EN to flag frames that are not odd-first, then even.
module arranged_frame_serializer #(
    parameter int unsigned NIB_W = 4,
    parameter int unsigned N     = 10,
    localparam int unsigned IDX_W = $clog2(N),
    localparam int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*NIB_W-1:0] in_frame,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NIB_W-1:0]   out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_odd,
    output logic               out_last,
    output logic [CNT_W-1:0]   odd_count,
    output logic               err
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [N*NIB_W-1:0] frame_q, frame_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   odd_count_q, odd_count_d;
    logic [N-1:0]       lsb;
    logic [CNT_W-1:0]   popcount;
    logic               accept;

    assign accept = (state_q == StIdle) && in_valid;

    // lsb[p] is the parity bit of the nibble at position p (position 0 sits in the MSBs)
    always_comb begin
        lsb      = '0;
        popcount = '0;
        for (int p = 0; p < N; p++) begin
            lsb[p]   = in_frame[(N - 1 - p) * NIB_W];
            popcount = popcount + CNT_W'(lsb[p]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            frame_q     <= '0;
            idx_q       <= '0;
            odd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            odd_count_q <= odd_count_d;
        end
    end

    // Frame shifts left on each handshake so the current nibble is always in the top slot
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        odd_count_d = odd_count_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d     = StSend;
                    frame_d     = in_frame;
                    idx_d       = '0;
                    odd_count_d = popcount;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (idx_q == IDX_W'(N - 1)) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        frame_d = frame_q << NIB_W;
                    end
                end
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StSend);
        out_data  = out_valid ? frame_q[N*NIB_W-1 -: NIB_W] : '0;
        out_idx   = idx_q;
        out_odd   = out_data[0];
        out_last  = out_valid && (idx_q == IDX_W'(N - 1));
        odd_count = odd_count_q;
    end

`ifdef ARRANGE_PARTITION_CHECK_EN
    logic partition_bad;
    logic err_q;

    // Odd-first ordering means the parity sequence never steps from even back to odd
    always_comb begin
        partition_bad = 1'b0;
        for (int p = 1; p < N; p++) begin
            if (lsb[p] && !lsb[p-1]) begin
                partition_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= partition_bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arranged_frame_serializer.sv
// Self-checking bench for arranged_frame_serializer: directed frames plus randomized frames
// and backpressure, checked against a per-position model of the expected stream.
module tb_arranged_frame_serializer;

    localparam int NIB_W = 4;
    localparam int N     = 10;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [N*NIB_W-1:0] in_frame;
    logic               out_valid;
    logic               out_ready;
    logic [NIB_W-1:0]   out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_odd;
    logic               out_last;
    logic [CNT_W-1:0]   odd_count;
    logic               err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [3:0] cur [N];

    arranged_frame_serializer #(
        .NIB_W(NIB_W),
        .N    (N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_frame (in_frame),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_odd  (out_odd),
        .out_last (out_last),
        .odd_count(odd_count),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*NIB_W-1:0] pack_frame(input logic [3:0] nib [N]);
        logic [N*NIB_W-1:0] f = '0;
        for (int p = 0; p < N; p++) f = (f << NIB_W) | (N*NIB_W)'(nib[p]);
        return f;
    endfunction

    function automatic int count_odd(input logic [3:0] nib [N]);
        int c = 0;
        for (int p = 0; p < N; p++) if (nib[p] % 2 == 1) c++;
        return c;
    endfunction

    // Violation: the last odd nibble comes after the first even nibble
    function automatic int model_err(input logic [3:0] nib [N]);
`ifdef ARRANGE_PARTITION_CHECK_EN
        int max_odd  = -1;
        int min_even = N;
        for (int p = 0; p < N; p++) begin
            if (nib[p] % 2 == 1) max_odd = p;
            else if (min_even == N) min_even = p;
        end
        return (max_odd > min_even) ? 1 : 0;
`else
        return (nib[0] === 4'hx) ? 1 : 0;
`endif
    endfunction

    // mode 0: ready held 1; 1: random ready; 2: 3-cycle stall at idx 4; 3: in_valid pulse mid-frame
    task automatic run_frame(input string name, input int mode, input int abort_at);
        logic [N*NIB_W-1:0] f;
        int ec, ee, pos, cyc, held;
        f    = pack_frame(cur);
        ec   = count_odd(cur);
        ee   = model_err(cur);
        pos  = 0;
        held = 0;
        cyc  = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " ready_before_load"}, 32'(in_ready), 32'(1));
        in_frame  = f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_frame = (N*NIB_W)'({$urandom(), $urandom()});
        cyc = 0;
        while (pos < N && cyc < 100) begin
            if (pos == abort_at) begin
                #3 rst_n = 1'b0;
                #1;
                chk({name, " rst out_valid"}, 32'(out_valid), 32'(0));
                chk({name, " rst in_ready"}, 32'(in_ready), 32'(1));
                chk({name, " rst odd_count"}, 32'(odd_count), 32'(0));
                chk({name, " rst err"}, 32'(err), 32'(0));
                chk({name, " rst out_idx"}, 32'(out_idx), 32'(0));
                chk({name, " rst out_data"}, 32'(out_data), 32'(0));
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            chk($sformatf("%s out_valid[%0d]", name, pos), 32'(out_valid), 32'(1));
            chk($sformatf("%s in_ready[%0d]", name, pos), 32'(in_ready), 32'(0));
            chk($sformatf("%s out_data[%0d]", name, pos), 32'(out_data), 32'(cur[pos]));
            chk($sformatf("%s out_idx[%0d]", name, pos), 32'(out_idx), 32'(pos));
            chk($sformatf("%s out_odd[%0d]", name, pos), 32'(out_odd), 32'(cur[pos] % 2));
            chk($sformatf("%s out_last[%0d]", name, pos), 32'(out_last), 32'(pos == N - 1));
            chk($sformatf("%s odd_count[%0d]", name, pos), 32'(odd_count), 32'(ec));
            chk($sformatf("%s err[%0d]", name, pos), 32'(err), 32'(ee));
            case (mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (pos == 4 && held < 3) begin
                        out_ready = 1'b0;
                        held++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
            in_valid = (mode == 3 && pos == 2);
            @(posedge clk); #1;
            if (out_ready) pos++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({name, " drained_in_budget"}, 32'(pos), 32'(N));
        chk({name, " idle out_valid"}, 32'(out_valid), 32'(0));
        chk({name, " idle in_ready"}, 32'(in_ready), 32'(1));
        chk({name, " idle odd_count"}, 32'(odd_count), 32'(ec));
        chk({name, " idle err"}, 32'(err), 32'(ee));
    endtask

    task automatic set_nominal();
        cur = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8, 4'd0};
    endtask

    initial begin
        clk       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_frame  = '0;
        out_ready = 1'b0;
        #3;
        chk("reset out_valid", 32'(out_valid), 32'(0));
        chk("reset in_ready", 32'(in_ready), 32'(1));
        chk("reset out_data", 32'(out_data), 32'(0));
        chk("reset out_idx", 32'(out_idx), 32'(0));
        chk("reset out_odd", 32'(out_odd), 32'(0));
        chk("reset out_last", 32'(out_last), 32'(0));
        chk("reset odd_count", 32'(odd_count), 32'(0));
        chk("reset err", 32'(err), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_nominal();
        run_frame("nominal", 0, -1);
        run_frame("backpressure", 2, -1);

        cur = '{4'd0, 4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0, 4'd2};
        run_frame("all_even", 0, -1);

        cur = '{4'd2, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd4, 4'd6, 4'd8, 4'd0};
        run_frame("bad_partition", 0, -1);
        set_nominal();
        run_frame("clear_err", 0, -1);

        run_frame("load_ignored", 3, -1);
        run_frame("reset_mid", 0, 4);
        chk("post_reset in_ready", 32'(in_ready), 32'(1));
        chk("post_reset odd_count", 32'(odd_count), 32'(0));
        cur = '{4'd3, 4'd11, 4'd4, 4'd0, 4'd6, 4'd14, 4'd2, 4'd8, 4'd10, 4'd12};
        run_frame("after_reset", 0, -1);

        for (int t = 0; t < 8; t++) begin
            int k;
            k = $urandom_range(0, N);
            for (int p = 0; p < N; p++) begin
                if (t % 2 == 0) cur[p] = 4'($urandom_range(0, 15));
                else if (p < k) cur[p] = 4'(($urandom_range(0, 7) << 1) | 1);
                else cur[p] = 4'($urandom_range(0, 7) << 1);
            end
            run_frame($sformatf("random%0d", t), 1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
